qspi_xfer_sched: RTL
====================

Name: qspi_xfer_sched

Overview:
- Sequences single-lane SPI flash transactions (opcode, optional 24-bit address, dummy clocks, read or write data bytes) on one shared set of flash pins.
- Round-robin arbitrates between two requesters: requester 0 (boot/ID fetch) and requester 1 (AXI-lite register path).
- Generates SCLK (mode 0) from the system clock.
- Replaces hard-wired single-command sequencing with a parameterised, shareable transaction engine.

Parameters:
- DIV, 2, SCLK half-period in clk cycles (legal ≥1); one bit period = 2*DIV clk.
- CSH, 4, minimum clk cycles ce stays high between transactions (legal ≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  2  request per requester (bit i = requester i), level
- req_op  in  16  opcode per requester, [8i+7:8i]
- req_addr  in  48  address per requester, [24i+23:24i]
- req_has_addr  in  2  1 = send 24-bit address phase
- req_dummy  in  8  dummy SCLK count per requester, [4i+3:4i], 0–15
- req_wr  in  2  1 = data phase writes, 0 = reads
- req_len  in  18  data byte count per requester, [9i+8:9i], 0–511
- gnt  out  2  one-hot owner, held for whole transaction
- wr_data  in  8  write byte from owner
- wr_ready  out  1  1-cycle pulse: wr_data consumed
- rd_data  out  8  received byte
- rd_valid  out  1  1-cycle pulse, no backpressure
- done  out  1  1-cycle pulse at end of transaction
- sclk  out  1  flash clock, idles low
- ce  out  1  flash chip enable, active low
- dout  out  1  flash MOSI
- din  in  1  flash MISO

Behaviour:
- Reset: gnt=0, wr_ready=0, rd_data=0, rd_valid=0, done=0, sclk=0, ce=1, dout=0, RR pointer favours requester 0, CSH counter loaded as satisfied. Reset mid-transaction aborts immediately: ce=1 and sclk=0 asynchronously; no done pulse.
- States: IDLE → CMD → ADDR → DUMMY → DATA → CSH → IDLE. Phases with zero length are skipped: ADDR when has_addr=0, DUMMY when dummy=0, DATA when len=0.
- Arbitration:
  - In IDLE with any req high at cycle T, the winner is latched and gnt asserts at T+1.
  - Both high: winner is the requester not granted last; the pointer updates on every grant.
  - All request fields are captured at T. Later changes and req deassertion are ignored until done.
- Transaction start: at T+1, ce=0, sclk=0, dout=opcode[7].
- SCLK and bit timing:
  - sclk rises DIV cycles after each bit is set up and falls DIV cycles after the rise.
  - din is sampled on the clk edge where sclk rises.
  - dout shifts to the next bit on the edge where sclk falls.
  - All bits are MSB first.
- Phase lengths:
  - CMD: 8 bits.
  - ADDR: 24 bits.
  - DUMMY: dummy full SCLK periods, dout=0.
  - DATA: 8*len bits.
- Write data:
  - wr_data is sampled and wr_ready pulses on the cycle the byte's bit 7 is driven: the first DATA cycle, then each 8th falling edge.
  - The owner must present the next byte before that cycle.
  - In read transactions, dout=0 during DATA.
- Read data: on the 8th sampling edge of each byte, rd_data updates and rd_valid pulses on the following cycle.
- End of transaction: after the last bit's falling edge, ce returns to 1 on the next cycle, with done pulsing and gnt clearing on that same cycle. The block then counts CSH cycles with ce=1 before IDLE may grant again.
- Counters: bit counter 5 bits, byte counter 9 bits; no wrap is possible because len ≤ 511.
- A request arriving during CSH is held pending and granted on the first IDLE cycle.

Test Plan:
- ID read: req0, op=0x9F, has_addr=0, dummy=0, len=3, din stream 0xEF,0x40,0x18 → 8 SCLK carrying 10011111, three rd_valid with rd_data EF/40/18, 32 sclk rises total, single done, ce low 32*2*DIV+1 cycles.
- Contention: req0 and req1 asserted together from reset → gnt=01 first. Both re-asserted together afterwards → gnt=10, then 01 (alternating); second grant no earlier than CSH cycles after ce rises.
- Page write: req1, op=0x02, addr=0x123456, wr, len=2, bytes A5/3C → dout sequence 02,12,34,56,A5,3C; exactly two wr_ready pulses; no rd_valid.
- Fast read: op=0x0B, addr=0x000100, dummy=8, len=1 → 8 dummy SCLK with dout=0 between address and data; one rd_valid.
- len=0 with has_addr=0 (op=0x06) → 8 SCLK only, done, no wr_ready/rd_valid.
- Reset mid-ADDR → ce=1, sclk=0, gnt=0 immediately. After release, a new req0 is granted normally.

Source files
------------

// File: rtl/qspi_xfer_sched.sv
// Single-lane SPI flash transaction engine shared by two requesters with
// round-robin arbitration; mode-0 SCLK derived from clk.
module qspi_xfer_sched #(
  parameter int DIV = 2,
  parameter int CSH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] req_op,
  input  logic [47:0] req_addr,
  input  logic [1:0]  req_has_addr,
  input  logic [7:0]  req_dummy,
  input  logic [1:0]  req_wr,
  input  logic [17:0] req_len,
  output logic [1:0]  gnt,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        sclk,
  output logic        ce,
  output logic        dout,
  input  logic        din
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;
  localparam logic [2:0] S_CSH   = 3'd6;

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (CSH > 1) ? $clog2(CSH) : 1;

  logic [2:0]    state;
  logic [2:0]    nxt_phase;
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] csh_cnt;
  logic          last;
  logic [4:0]    bitcnt;
  logic [8:0]    bytecnt;
  logic [23:0]   sh;
  logic [7:0]    rsh;
  logic [23:0]   f_addr;
  logic          f_has_addr;
  logic [3:0]    f_dummy;
  logic          f_wr;
  logic [8:0]    f_len;

  logic          win;
  logic [7:0]    op_sel;
  logic [23:0]   addr_sel;
  logic          has_addr_sel;
  logic [3:0]    dummy_sel;
  logic          wr_sel;
  logic [8:0]    len_sel;

  // Requester 1 wins when alone, or on contention when requester 0 was granted last.
  always_comb begin
    win          = req[1] & (~req[0] | ~last);
    op_sel       = win ? req_op[15:8]    : req_op[7:0];
    addr_sel     = win ? req_addr[47:24] : req_addr[23:0];
    has_addr_sel = win ? req_has_addr[1] : req_has_addr[0];
    dummy_sel    = win ? req_dummy[7:4]  : req_dummy[3:0];
    wr_sel       = win ? req_wr[1]       : req_wr[0];
    len_sel      = win ? req_len[17:9]   : req_len[8:0];
  end

  always_comb begin
    nxt_phase = S_END;
    case (state)
      S_CMD:   nxt_phase = f_has_addr ? S_ADDR :
                           (f_dummy != 4'd0) ? S_DUMMY :
                           (f_len != 9'd0) ? S_DATA : S_END;
      S_ADDR:  nxt_phase = (f_dummy != 4'd0) ? S_DUMMY :
                           (f_len != 9'd0) ? S_DATA : S_END;
      S_DUMMY: nxt_phase = (f_len != 9'd0) ? S_DATA : S_END;
      default: nxt_phase = S_END;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      csh_cnt    <= '0;
      last       <= 1'b1;
      bitcnt     <= '0;
      bytecnt    <= '0;
      sh         <= '0;
      rsh        <= '0;
      f_addr     <= '0;
      f_has_addr <= 1'b0;
      f_dummy    <= '0;
      f_wr       <= 1'b0;
      f_len      <= '0;
      gnt        <= '0;
      wr_ready   <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      sclk       <= 1'b0;
      ce         <= 1'b1;
      dout       <= 1'b0;
    end else begin
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req != 2'b00) begin
            gnt        <= win ? 2'b10 : 2'b01;
            last       <= win;
            f_addr     <= addr_sel;
            f_has_addr <= has_addr_sel;
            f_dummy    <= dummy_sel;
            f_wr       <= wr_sel;
            f_len      <= len_sel;
            sh         <= {op_sel, 16'h0000};
            dout       <= op_sel[7];
            bitcnt     <= 5'd7;
            div_cnt    <= '0;
            sclk       <= 1'b0;
            ce         <= 1'b0;
            state      <= S_CMD;
          end
        end
        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              if (state == S_DATA && !f_wr) begin
                rsh <= {rsh[6:0], din};
                if (bitcnt == 5'd0) begin
                  rd_data  <= {rsh[6:0], din};
                  rd_valid <= 1'b1;
                end
              end
            end else if (bitcnt != 5'd0) begin
              bitcnt <= bitcnt - 5'd1;
              sh     <= {sh[22:0], 1'b0};
              dout   <= sh[22];
            end else if (state == S_DATA && bytecnt != 9'd0) begin
              bytecnt <= bytecnt - 9'd1;
              bitcnt  <= 5'd7;
              if (f_wr) begin
                sh       <= {wr_data, 16'h0000};
                dout     <= wr_data[7];
                wr_ready <= 1'b1;
              end else begin
                sh   <= '0;
                dout <= 1'b0;
              end
            end else begin
              state <= nxt_phase;
              case (nxt_phase)
                S_ADDR: begin
                  sh     <= f_addr;
                  dout   <= f_addr[23];
                  bitcnt <= 5'd23;
                end
                S_DUMMY: begin
                  sh     <= '0;
                  dout   <= 1'b0;
                  bitcnt <= {1'b0, f_dummy} - 5'd1;
                end
                S_DATA: begin
                  bitcnt  <= 5'd7;
                  bytecnt <= f_len - 9'd1;
                  if (f_wr) begin
                    sh       <= {wr_data, 16'h0000};
                    dout     <= wr_data[7];
                    wr_ready <= 1'b1;
                  end else begin
                    sh   <= '0;
                    dout <= 1'b0;
                  end
                end
                default: begin
                  sh   <= '0;
                  dout <= 1'b0;
                end
              endcase
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        S_END: begin
          ce      <= 1'b1;
          done    <= 1'b1;
          gnt     <= '0;
          csh_cnt <= CW'(CSH - 1);
          state   <= S_CSH;
        end
        S_CSH: begin
          if (csh_cnt == '0) state <= S_IDLE;
          else csh_cnt <= csh_cnt - CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
